// File: rtl/sub_serial_8.sv
// Bit-serial 8-bit subtractor (a - b - b_in), one bit per cycle, LSB first.
// Latency: 8 RUN cycles then a 1-cycle DONE pulse; start is ignored while busy (no backpressure otherwise).
module sub_serial_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] diff,
    output logic       b_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_sh_q, a_sh_d;
    logic [7:0] b_sh_q, b_sh_d;
    logic [7:0] res_q, res_d;
    logic       br_q, br_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] diff_q, diff_d;
    logic       b_out_q, b_out_d;

    logic a0, b0, d_bit, br_nxt;

    always_comb begin
        a0     = a_sh_q[0];
        b0     = b_sh_q[0];
        d_bit  = a0 ^ b0 ^ br_q;
        br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = b_in;
                    res_d   = 8'h00;
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = {1'b0, a_sh_q[7:1]};
                b_sh_d = {1'b0, b_sh_q[7:1]};
                res_d  = {d_bit, res_q[7:1]};
                br_d   = br_nxt;
                cnt_d  = cnt_q + 3'd1;
                // Last bit: publish the result including this cycle's difference bit.
                if (cnt_q == 3'd7) begin
                    diff_d  = {d_bit, res_q[7:1]};
                    b_out_d = br_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= 8'h00;
            b_sh_q  <= 8'h00;
            res_q   <= 8'h00;
            br_q    <= 1'b0;
            cnt_q   <= 3'd0;
            diff_q  <= 8'h00;
            b_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign diff  = diff_q;
    assign b_out = b_out_q;

endmodule

// File: tb/tb_sub_serial_8.sv
// Bench for sub_serial_8: cycle model of the serial subtractor plus directed literal cases.
module tb_sub_serial_8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       b_out;

    int total = 0;
    int bad   = 0;

    sub_serial_8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an operation occupies 9 cycles (8 computing + 1 done);
    // the result is published when the done cycle begins.
    int         remain   = 0;
    logic [7:0] m_a      = 8'h00;
    logic [7:0] m_b      = 8'h00;
    logic       m_bin    = 1'b0;
    logic [7:0] exp_diff = 8'h00;
    logic       exp_bout = 1'b0;
    int         runs     = 0;
    bit         cmp_en   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            remain   = 0;
            exp_diff = 8'h00;
            exp_bout = 1'b0;
        end else if (remain == 0) begin
            if (start) begin
                m_a    = a;
                m_b    = b;
                m_bin  = b_in;
                remain = 9;
            end
        end else begin
            remain = remain - 1;
            if (remain == 1) begin
                exp_diff = 8'((int'(m_a) - int'(m_b) - int'(m_bin)) & 255);
                exp_bout = (int'(m_a) < int'(m_b) + int'(m_bin));
                runs++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy",  32'(busy),  32'(remain > 0));
            chk("model_done",  32'(done),  32'(remain == 1));
            chk("model_diff",  32'(diff),  32'(exp_diff));
            chk("model_b_out", 32'(b_out), 32'(exp_bout));
        end
    end

    // Pulse start for one edge, then measure latency and busy duration.
    task automatic do_op(input string nm, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ibin, input logic [7:0] ed, input logic ebo);
        int edges;
        int busy_cyc;
        edges    = 0;
        busy_cyc = 0;
        @(negedge clk);
        a = ia; b = ib; b_in = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        if (busy) busy_cyc++;
        while (!done && edges < 20) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cyc++;
        end
        chk({nm, "_latency"}, 32'(edges), 32'd9);
        chk({nm, "_busy_cycles"}, 32'(busy_cyc), 32'd9);
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_b_out"}, 32'(b_out), 32'(ebo));
        @(negedge clk);
        chk({nm, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int gap;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; b_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_diff",  32'(diff),  32'd0);
        chk("reset_b_out", 32'(b_out), 32'd0);
        rst = 1'b0;

        do_op("5A_3C", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        do_op("00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        do_op("80_7F", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        do_op("FF_FF", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start held high, operands disturbed mid-run
        @(negedge clk);
        a = 8'h33; b = 8'h11; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 20) begin
            a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("hold_start_diff", 32'(diff), 32'h22);
        a = 8'h40; b = 8'h05; b_in = 1'b1;
        gap = 0;
        @(negedge clk);
        gap = 1;
        while (!done && gap < 30) begin
            @(negedge clk);
            gap++;
        end
        chk("hold_start_interval", 32'(gap), 32'd10);
        chk("hold_start_diff2", 32'(diff), 32'h3A);
        start = 1'b0;
        @(negedge clk);

        // reset on the 4th computing edge, restart right after
        a = 8'hC3; b = 8'h21; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_done",  32'(done),  32'd0);
        chk("abort_diff",  32'(diff),  32'd0);
        chk("abort_b_out", 32'(b_out), 32'd0);
        do_op("10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

        // randomised traffic against the model
        begin
            int base;
            base = runs;
            cyc  = 0;
            while (runs - base < 1000 && cyc < 30000) begin
                start = ($urandom_range(3) != 0);
                a     = 8'($urandom);
                b     = 8'($urandom);
                b_in  = 1'($urandom);
                rst   = ($urandom_range(499) == 0);
                @(negedge clk);
                cyc++;
            end
            chk("random_runs_done", 32'(runs - base >= 1000), 32'd1);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
